// File: rtl/regfile_if.sv
// Register-file port bundle between the ID/WB stages and the register storage.
// One write port (WB) and two combinational read ports (ID).
interface regfile_if #(
    parameter int DATA_W = 64
);
    // Protocol: no valid/ready pairing. A write is committed on the rising clk
    // edge whenever RegWrite is high (and WriteRegister != 31); reads are
    // purely combinational from the address inputs and see same-cycle writes.
    logic              RegWrite;
    logic [4:0]        WriteRegister;
    logic [DATA_W-1:0] WriteData;
    logic [4:0]        ReadRegister1;
    logic [4:0]        ReadRegister2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;

    modport master (
        output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        input  ReadData1, ReadData2
    );

    modport slave (
        input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        output ReadData1, ReadData2
    );
endinterface

// File: rtl/regfile.sv
// 32 x DATA_W register file with one write port, two combinational read ports,
// same-cycle write-through forwarding and a hardwired-zero X31 (XZR).
module regfile #(
    parameter int DATA_W = 64,
    parameter int NREGS  = 32
) (
    input logic      clk,
    input logic      reset,
    regfile_if.slave rf
);
    localparam logic [4:0] ZERO_REG = 5'd31;

    // Only X0..X30 have storage; X31 is synthesised as a constant zero.
    logic [DATA_W-1:0] regs [0:NREGS-2];
    logic [NREGS-2:0]  writeEnable;

    always_comb begin
        writeEnable = '0;
        for (int i = 0; i < NREGS - 1; i++) begin
            writeEnable[i] = rf.RegWrite && (rf.WriteRegister == 5'(i));
        end
    end

    for (genvar g = 0; g < NREGS - 1; g++) begin : gWord
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                regs[g] <= '0;
            end else if (writeEnable[g]) begin
                regs[g] <= rf.WriteData;
            end
        end
    end

    // Priority: XZR/reset zero, then forwarding of the in-flight write, then storage.
    always_comb begin
        rf.ReadData1 = '0;
        if (reset || rf.ReadRegister1 == ZERO_REG) begin
            rf.ReadData1 = '0;
        end else if (rf.RegWrite && rf.WriteRegister == rf.ReadRegister1) begin
            rf.ReadData1 = rf.WriteData;
        end else begin
            rf.ReadData1 = regs[rf.ReadRegister1];
        end
    end

    always_comb begin
        rf.ReadData2 = '0;
        if (reset || rf.ReadRegister2 == ZERO_REG) begin
            rf.ReadData2 = '0;
        end else if (rf.RegWrite && rf.WriteRegister == rf.ReadRegister2) begin
            rf.ReadData2 = rf.WriteData;
        end else begin
            rf.ReadData2 = regs[rf.ReadRegister2];
        end
    end
endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: shadow register model feeds an expected
// queue that is drained against both read ports.
module tb_regfile;
    localparam int W = 64;

    logic clk;
    logic reset;
    regfile_if #(.DATA_W(W)) rf ();

    regfile #(.DATA_W(W), .NREGS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .rf    (rf)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks_total;
    int checks_passed;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] model [0:31];

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks_total++;
        if (obs === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] expected_read(input logic [4:0] addr);
        if (reset || addr == 5'd31) return '0;
        if (rf.RegWrite && rf.WriteRegister == addr) return rf.WriteData;
        return model[addr];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    // Driver tasks
    task automatic drive_write(input logic en, input logic [4:0] addr, input logic [W-1:0] data);
        rf.RegWrite      = en;
        rf.WriteRegister = addr;
        rf.WriteData     = data;
    endtask

    // Present read addresses, push expectations, then compare 1 ns later.
    task automatic read_check(input string tag, input logic [4:0] a1, input logic [4:0] a2);
        rf.ReadRegister1 = a1;
        rf.ReadRegister2 = a2;
        exp_q.push_back(expected_read(a1));
        exp_q.push_back(expected_read(a2));
        #1;
        check($sformatf("%s_p1_x%0d", tag, a1), rf.ReadData1, exp_q.pop_front());
        check($sformatf("%s_p2_x%0d", tag, a2), rf.ReadData2, exp_q.pop_front());
    endtask

    // Advance through one rising edge, committing the model, and return at negedge.
    task automatic step_edge();
        @(posedge clk);
        if (!reset && rf.RegWrite && rf.WriteRegister != 5'd31)
            model[rf.WriteRegister] = rf.WriteData;
        @(negedge clk);
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        clear_model();
        reset = 1'b1;
        drive_write(1'b0, 5'd0, '0);
        rf.ReadRegister1 = 5'd0;
        rf.ReadRegister2 = 5'd0;

        // Reset state at power-up
        @(negedge clk);
        read_check("rst_hold", 5'd0, 5'd30);
        reset = 1'b0;
        @(negedge clk);

        // Populate a register, then pulse reset asynchronously mid-cycle
        drive_write(1'b1, 5'd3, 64'h1234);
        step_edge();
        drive_write(1'b1, 5'd4, 64'hCAFE);
        #2 reset = 1'b1;
        clear_model();
        read_check("rst_fwd_blocked", 5'd4, 5'd3);
        #1 reset = 1'b0;
        drive_write(1'b0, 5'd0, '0);
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            read_check("rst_sweep", 5'(i), 5'(31 - i));
            @(negedge clk);
        end

        // Write/read back on consecutive edges
        drive_write(1'b1, 5'd5, 64'h0123_4567_89AB_CDEF);
        step_edge();
        drive_write(1'b1, 5'd30, 64'hFFFF_FFFF_FFFF_FFFF);
        step_edge();
        drive_write(1'b0, 5'd0, '0);
        read_check("wr_rd", 5'd5, 5'd30);
        read_check("wr_rd", 5'd30, 5'd5);
        for (int i = 0; i < 32; i++) begin
            read_check("wr_sweep", 5'(i), 5'(i));
        end
        @(negedge clk);

        // Enable gating: a held write with RegWrite low never lands
        drive_write(1'b0, 5'd5, 64'hDEAD);
        read_check("gate_fwd", 5'd5, 5'd5);
        for (int i = 0; i < 3; i++) step_edge();
        read_check("gate", 5'd5, 5'd5);
        check("gate_x5_value", rf.ReadData1, 64'h0123_4567_89AB_CDEF);

        // XZR ignores writes and always reads zero
        drive_write(1'b1, 5'd31, 64'h1234);
        read_check("xzr_same", 5'd31, 5'd31);
        step_edge();
        drive_write(1'b0, 5'd0, '0);
        read_check("xzr_after", 5'd31, 5'd31);
        check("xzr_zero", rf.ReadData2, '0);

        // Forwarding
        drive_write(1'b1, 5'd7, 64'hA);
        step_edge();
        drive_write(1'b0, 5'd7, 64'hB);
        read_check("fwd_off", 5'd7, 5'd7);
        check("fwd_off_val", rf.ReadData1, 64'hA);
        drive_write(1'b1, 5'd7, 64'hB);
        read_check("fwd_on", 5'd7, 5'd7);
        check("fwd_on_val", rf.ReadData2, 64'hB);
        step_edge();
        drive_write(1'b0, 5'd0, '0);
        read_check("fwd_stored", 5'd7, 5'd7);

        // Reset 1 ns before an edge that would write X9
        drive_write(1'b1, 5'd9, 64'h55);
        step_edge();
        drive_write(1'b1, 5'd9, 64'h77);
        #4 reset = 1'b1;
        clear_model();
        @(posedge clk);
        #1;
        read_check("rst_wr_hold", 5'd9, 5'd9);
        drive_write(1'b0, 5'd0, '0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        read_check("rst_wr_after", 5'd9, 5'd9);
        check("rst_wr_x9_zero", rf.ReadData1, '0);
        @(negedge clk);

        // Random traffic against the model
        for (int n = 0; n < 40; n++) begin
            drive_write(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                        {32'($urandom), 32'($urandom)});
            read_check("rand", 5'($urandom_range(0, 31)),
                       (n % 4 == 0) ? rf.WriteRegister : 5'($urandom_range(0, 31)));
            step_edge();
        end
        drive_write(1'b0, 5'd0, '0);
        for (int i = 0; i < 32; i++) begin
            read_check("final_sweep", 5'(i), 5'(31 - i));
        end

        if (exp_q.size() != 0) begin
            checks_total++;
            $display("FAIL exp_q_drain: got %0d left, want 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule

// File: doc/regfile.md
# regfile

32-entry × 64-bit register file for the ID/WB boundary of the 5-stage ARM (LEGv8-style) pipeline. It is the read side of the enable-gated register storage: the WB stage writes through one port, and the ID stage reads two operands combinationally. Same-cycle write-through forwarding removes the WB→ID structural hazard. Register X31 (XZR) always reads zero and ignores writes.

## Interface

Parameters:
- `DATA_W`, 64, register width in bits.
- `NREGS`, 32, number of architectural registers (must be 32; addresses are 5 bits).

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high; clears all storage.
- `RegWrite`  input  1  write enable from the WB stage.
- `WriteRegister`  input  5  write address.
- `WriteData`  input  DATA_W  write data.
- `ReadRegister1`  input  5  read port 1 address (Rn).
- `ReadRegister2`  input  5  read port 2 address (Rm/Rd).
- `ReadData1`  output  DATA_W  read port 1 data.
- `ReadData2`  output  DATA_W  read port 2 data.

Clock/reset: one clock; reset is asynchronous and active-high.

## Operation

- **Storage:** registers X0–X30 are 64-bit enable-gated flip-flop words.
  - Each word loads `WriteData` on a rising edge only when `RegWrite`=1 and `WriteRegister` selects it.
  - Otherwise each word holds its value.
- **Write decode:** a 5→32 decoder gated by `RegWrite`. At most one word is enabled per cycle.
- **X31:** no storage. A write to address 31 is discarded. Reads of address 31 return 0 regardless of any other input.
- **Read path:** each port selects from the 32 words combinationally through a 32:1 mux per bit.
- **Write-through forwarding:** the value on `ReadDataN` is chosen in this priority order.
  1. If `ReadRegisterN`==31, output 0.
  2. Else if `RegWrite`=1 and `WriteRegister`==`ReadRegisterN`, output `WriteData` (the value being written this cycle).
  3. Else output the stored word.
- **Independent ports:** both ports may address the same register, and both may hit the forwarding path in the same cycle.
- **Reset:** asserting `reset` clears X0–X30 to 0 immediately, without waiting for `clk`.
  - While `reset`=1, writes are blocked. The forwarding path is also suppressed, so both read ports output 0.
  - Deassertion is synchronous-safe: the first write can occur on the first rising edge after `reset` falls.

## Timing

- **Reset values:** `ReadData1` = `ReadData2` = 0, for every address, while reset is asserted and immediately after it.
- **Read latency:** 0 cycles, purely combinational from the address inputs, the storage, and the forwarding inputs.
- **Write latency:** the written value is visible in the same cycle via forwarding. It is held in storage from the rising edge onward.
- **`RegWrite` timing:** must be stable around the rising edge. A glitch between edges affects only the combinational forwarding, never the stored state.
- **Reset mid-cycle:** an asynchronous assert between edges drops the outputs to 0 within propagation delay. A write pending on the next edge is lost.
- **Critical path:** read address → 32:1 mux → forwarding mux → output. It must fit within the ID stage alongside the control decode.

## Test plan

- **Reset:** pulse `reset` asynchronously mid-cycle, then sweep `ReadRegister1`/`ReadRegister2` over 0–31.
  - Required: all reads return 0.
- **Write/read back:** write X5=64'h0123_4567_89AB_CDEF and X30=64'hFFFF_FFFF_FFFF_FFFF on consecutive edges, then read 5 and 30 on both ports.
  - Required: exact values; all other registers are still 0.
- **Enable gating:** with `RegWrite`=0, present `WriteRegister`=5 and `WriteData`=64'hDEAD for 3 edges.
  - Required: X5 is unchanged (still 64'h0123_4567_89AB_CDEF).
- **XZR:** write address 31 with 64'h1234, `RegWrite`=1.
  - Required: reads of 31 return 0 both in that cycle and after the edge.
- **Forwarding:** X7 holds 64'hA. In the same cycle, set `RegWrite`=1, `WriteRegister`=7, `WriteData`=64'hB, and `ReadRegister1`=`ReadRegister2`=7.
  - Required: both outputs are 64'hB before the edge, and X7 holds 64'hB after it.
  - With `RegWrite`=0 and the same stimulus, both outputs must read 64'hA.
- **Reset during write:** X9 holds 64'h55. Assert `reset` 1 ns before an edge that would write X9=64'h77.
  - Required: X9 reads 0 after reset is released; no write occurs.
